// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
// Arbitrates the CPU's instruction-fetch and data ports onto one Avalon-style
// memory bus, one transaction at a time. A winning request is latched into
// registered bus fields and held through waitrequest. The winner then gets a
// one-cycle acknowledge together with its read data.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to resolve a simultaneous
// request in favour of the requester that did not own the previous completed
// transaction. Without it, a data access always wins a tie.
module mips_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  // instruction-fetch port
  input  logic        instr_req,
  input  logic [31:0] instr_address,
  output logic        instr_ack,
  output logic [31:0] instr_readdata,
  // data port
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic        data_ack,
  output logic [31:0] data_readdata,
  // memory bus
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  // owner of the current or last transaction (1 = data)
  output logic        grant_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Registered bus fields, latched at grant and held for the whole transaction.
  logic [31:0] address_reg;
  logic        read_reg;
  logic        write_reg;
  logic [31:0] writedata_reg;
  logic [3:0]  byteenable_reg;
  logic        grant_data_reg;

  // Field values the bus would take if the current IDLE cycle grants.
  logic [31:0] address_next;
  logic        read_next;
  logic        write_next;
  logic [31:0] writedata_next;
  logic [3:0]  byteenable_next;

  logic data_pend;
  logic instr_pend;
  logic tie_pick_data;
  logic pick_data;
  logic grant_valid;
  logic latch_grant;
  logic bus_done;

  // The byte-offset bits never reach the bus; the bus is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_address[1:0], data_address[1:0]};

  // Pick a winner among the pending requesters.
  always_comb begin
    data_pend  = data_read | data_write;
    instr_pend = instr_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // grant_data_reg holds the owner of the last completed transaction.
    // It is cleared by reset, so the first tie after reset goes to data.
    tie_pick_data = ~grant_data_reg;
`else
    tie_pick_data = 1'b1;
`endif
    grant_valid = data_pend | instr_pend;
    pick_data   = data_pend & (~instr_pend | tie_pick_data);
  end

  // Build the bus fields for the chosen requester.
  always_comb begin
    address_next    = {instr_address[31:2], 2'b00};
    read_next       = 1'b1;
    write_next      = 1'b0;
    writedata_next  = 32'h0;
    byteenable_next = 4'b1111;
    if (pick_data) begin
      address_next    = {data_address[31:2], 2'b00};
      // A store wins over a load when both strobes are raised together.
      write_next      = data_write;
      read_next       = ~data_write;
      writedata_next  = data_writedata;
      byteenable_next = data_byteenable;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and the two transition qualifiers used by the datapath.
  always_comb begin
    state_next  = state_reg;
    latch_grant = 1'b0;
    bus_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          latch_grant = 1'b1;
          state_next  = BUS;
        end
      end
      BUS: begin
        if (!waitrequest) begin
          bus_done   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bus field registers: load on grant, drop the strobes once the bus accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      address_reg    <= 32'h0;
      read_reg       <= 1'b0;
      write_reg      <= 1'b0;
      writedata_reg  <= 32'h0;
      byteenable_reg <= 4'h0;
      grant_data_reg <= 1'b0;
    end else if (latch_grant) begin
      address_reg    <= address_next;
      read_reg       <= read_next;
      write_reg      <= write_next;
      writedata_reg  <= writedata_next;
      byteenable_reg <= byteenable_next;
      grant_data_reg <= pick_data;
    end else if (bus_done) begin
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
    end
  end

  // One acknowledge/readdata slice per requester: gi = 0 fetch, gi = 1 data.
  // The ack is raised on the edge entering DONE, so it is high for exactly
  // the DONE cycle. Only the owner of a read updates its data register.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      localparam bit IS_DATA = (gi == 1);
      logic        ack_reg;
      logic [31:0] rdata_reg;

      // Ack pulse and read-data capture for this requester.
      always_ff @(posedge clk) begin
        if (reset) begin
          ack_reg   <= 1'b0;
          rdata_reg <= 32'h0;
        end else begin
          ack_reg <= bus_done && (grant_data_reg == IS_DATA);
          if (bus_done && read_reg && (grant_data_reg == IS_DATA)) begin
            rdata_reg <= readdata;
          end
        end
      end
    end
  endgenerate

  assign instr_ack      = g_req[0].ack_reg;
  assign instr_readdata = g_req[0].rdata_reg;
  assign data_ack       = g_req[1].ack_reg;
  assign data_readdata  = g_req[1].rdata_reg;

  assign address    = address_reg;
  assign read       = read_reg;
  assign write      = write_reg;
  assign writedata  = writedata_reg;
  assign byteenable = byteenable_reg;
  assign grant_data = grant_data_reg;

endmodule
